fb_pixel_writer: RTL

Frame-buffer write side of the double-buffered SRAM display path. It accepts shaded pixels `(x, y, rgb)` from the ray-cast pipeline and converts each one to a linear frame-buffer address. Pixels are buffered in a small FIFO and issued as single-word write requests toward the SRAM port owned by the renderer/scan-out logic. At end of frame it waits for vertical blanking and swaps the read/write buffer halves, so scan-out never shows a partially drawn frame.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/fb_pixel_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and helpers for the SRAM display path.
package fb_pkg;

    localparam int H_RES     = 800;
    localparam int V_RES     = 600;
    localparam int FB_ADDR_W = 19;

    // One queued frame-buffer write: linear word address plus 24-bit colour.
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [23:0]          rgb;
    } fb_pix_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        WAIT_VB
    } fbw_state_e;

    // Linear address y*h_res + x. The 800-wide case is y*512 + y*256 + y*32 + x,
    // which keeps the adder tree free of a hard multiplier.
    function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(
        input logic [9:0]  x,
        input logic [9:0]  y,
        input int unsigned h_res
    );
        logic [FB_ADDR_W-1:0] xw;
        logic [FB_ADDR_W-1:0] yw;
        xw = {{(FB_ADDR_W-10){1'b0}}, x};
        yw = {{(FB_ADDR_W-10){1'b0}}, y};
        if (h_res == 32'd800) begin
            return (yw << 9) + (yw << 8) + (yw << 5) + xw;
        end
        return FB_ADDR_W'(yw * FB_ADDR_W'(h_res)) + xw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; shared by SRAM clients.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_in,
    input  logic             reset_btn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy update; push and pop together leave count unchanged.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; asynchronous reset empties the FIFO immediately.
    always_ff @(posedge clk_in or posedge reset_btn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset_btn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only ever read behind a non-empty count.
    always_ff @(posedge clk_in) begin
        // NOTE: storage is deliberately not reset; empty gates every read, so a reset buys nothing.
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

    a_no_push_full: assert property (@(posedge clk_in) disable iff (reset_btn) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_in) disable iff (reset_btn) !(pop && empty));

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write side: pixel -> address, FIFO to SRAM port, vblank-aligned buffer swap.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = fb_pkg::H_RES,
    parameter int V_RES      = fb_pkg::V_RES,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_in,
    input  logic                 reset_btn,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic [23:0]          pix_rgb,
    input  logic                 pix_last,
    input  logic                 vblank,
    output logic                 wr_req,
    input  logic                 wr_grant,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic                 wr_addr_offset,
    output logic                 rd_addr_offset,
    output logic                 frame_done,
    output logic                 drop
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [10:0]     X_LIM   = 11'(H_RES);
    localparam logic [10:0]     Y_LIM   = 11'(V_RES);
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    fbw_state_e state_q, state_d;
    logic       ready_en_q, ready_en_d;
    logic       s1_valid_q, s1_valid_d;
    logic       s1_ok_q, s1_ok_d;
    fb_pix_t    s1_pix_q, s1_pix_d;
    logic       wr_off_q, wr_off_d;
    logic       frame_done_q, frame_done_d;

    logic          hs;
    logic          push;
    logic          pop;
    logic          drain_done;
    logic [CW-1:0] occ;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    fb_pix_t       head;

    // Handshake and flow control: stage-1 plus FIFO may never exceed the FIFO depth.
    assign hs         = pix_valid && pix_ready;
    assign occ        = fifo_count + CW'(s1_valid_q);
    assign pix_ready  = ready_en_q && (state_q == RUN) && (occ < DEPTH_C);
    assign push       = s1_valid_q && s1_ok_q;
    assign pop        = wr_req && wr_grant;
    assign drop       = s1_valid_q && !s1_ok_q;
    // Last entry leaving this cycle counts as drained so the swap can follow one cycle later.
    assign drain_done = !s1_valid_q && (fifo_empty || ((fifo_count == CW'(1)) && pop));

    // Stage-1 capture: address, colour and range check of each accepted pixel.
    always_comb begin
        s1_valid_d = hs;
        s1_ok_d    = s1_ok_q;
        s1_pix_d   = s1_pix_q;
        if (hs) begin
            s1_ok_d       = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);
            s1_pix_d.addr = fb_linear_addr(pix_x, pix_y, H_RES);
            s1_pix_d.rgb  = pix_rgb;
        end
    end

    // Frame sequencing: stop accepting after the last pixel, drain, then swap in vblank.
    always_comb begin
        state_d      = state_q;
        wr_off_d     = wr_off_q;
        frame_done_d = 1'b0;
        ready_en_d   = 1'b1;
        unique case (state_q)
            RUN: begin
                if (hs && pix_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_d = WAIT_VB;
            end
            WAIT_VB: begin
                if (vblank) begin
                    wr_off_d     = !wr_off_q;
                    frame_done_d = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State registers; reset discards any pending swap and restores the buffer halves.
    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            state_q      <= RUN;
            ready_en_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_ok_q      <= 1'b0;
            s1_pix_q     <= '0;
            wr_off_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= ready_en_d;
            s1_valid_q   <= s1_valid_d;
            s1_ok_q      <= s1_ok_d;
            s1_pix_q     <= s1_pix_d;
            wr_off_q     <= wr_off_d;
            frame_done_q <= frame_done_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fb_pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset_btn (reset_btn),
        .push      (push),
        .push_data (s1_pix_q),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write port is driven from the FIFO head and held at zero while idle.
    assign wr_req         = !fifo_empty;
    assign wr_addr        = wr_req ? head.addr : '0;
    assign wr_data        = wr_req ? {8'h00, head.rgb} : 32'h0;
    assign wr_addr_offset = wr_off_q;
    assign rd_addr_offset = ~wr_off_q;
    assign frame_done     = frame_done_q;

endmodule
